// File: rtl/direction_input_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------------+
// | direction_input_ctrl : debounced active-low buttons -> one-hot move commands  |
// | Optional AUTO_REPEAT_EN re-issues a held direction.          Revision: 1.0    |
// +------------------------------------------------------------------------------+
module direction_input_ctrl #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int HOLD_CYCLES     = 4,
   parameter int REPEAT_CYCLES   = 25000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] btn_n,
   input  logic       enable,
   output logic [3:0] direction,
   output logic [3:0] btn_stable,
   output logic       busy
);
   localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
   localparam logic [DB_W-1:0]   DB_MAX    = DB_W'(DEBOUNCE_CYCLES);
   localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES);

   typedef enum logic [1:0] {
      WAIT_PRESS   = 2'd0,
      ISSUE        = 2'd1,
      WAIT_RELEASE = 2'd2
   } state_t;

   logic [3:0]        sync1_q, sync1_d, sync2_q, sync2_d;
   logic [3:0]        stable_q, stable_d, stable_prev_q, stable_prev_d;
   logic [DB_W-1:0]   db_cnt_q [4];
   logic [DB_W-1:0]   db_cnt_d [4];
   state_t            state_q, state_d;
   logic [3:0]        dir_q, dir_d, latched_q, latched_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic [3:0]        s, press, first;

`ifdef AUTO_REPEAT_EN
   localparam int REP_W = $clog2(REPEAT_CYCLES + 1);
   localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);
   logic [REP_W-1:0]  rep_q, rep_d;
`else
   logic unused_repeat_cycles;
   assign unused_repeat_cycles = (REPEAT_CYCLES != 0);
`endif

   assign s     = ~sync2_q;
   assign press = stable_q & ~stable_prev_q;
   // Lowest set bit wins: up > down > left > right.
   assign first = press & (~press + 4'd1);

   always_comb begin
      sync1_d       = btn_n;
      sync2_d       = sync1_q;
      stable_prev_d = stable_q;
      stable_d      = stable_q;
      for (int i = 0; i < 4; i++) begin
         db_cnt_d[i] = '0;
         if (s[i] != stable_q[i]) begin
            if (db_cnt_q[i] == DB_MAX) begin
               stable_d[i] = s[i];
            end else begin
               db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
            end
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      dir_d     = 4'b0000;
      latched_d = latched_q;
      hold_d    = hold_q;
`ifdef AUTO_REPEAT_EN
      rep_d     = '0;
`endif
      unique case (state_q)
         WAIT_PRESS: begin
            if (enable && (press != 4'b0000)) begin
               latched_d = first;
               dir_d     = first;
               hold_d    = HOLD_LOAD;
               state_d   = ISSUE;
            end
         end
         ISSUE: begin
            if (!enable || (hold_q <= HOLD_W'(1))) begin
               hold_d  = '0;
               state_d = WAIT_RELEASE;
            end else begin
               dir_d  = latched_q;
               hold_d = hold_q - HOLD_W'(1);
            end
         end
         WAIT_RELEASE: begin
            if (stable_q == 4'b0000) begin
               state_d = WAIT_PRESS;
            end
`ifdef AUTO_REPEAT_EN
            else if ((stable_q == latched_q) && enable) begin
               if (rep_q >= REP_LAST) begin
                  dir_d   = latched_q;
                  hold_d  = HOLD_LOAD;
                  state_d = ISSUE;
               end else begin
                  rep_d = rep_q + REP_W'(1);
               end
            end
`endif
         end
         default: state_d = WAIT_PRESS;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q       <= 4'b1111;
         sync2_q       <= 4'b1111;
         stable_q      <= 4'b0000;
         stable_prev_q <= 4'b0000;
         for (int i = 0; i < 4; i++) db_cnt_q[i] <= '0;
         state_q       <= WAIT_PRESS;
         dir_q         <= 4'b0000;
         latched_q     <= 4'b0000;
         hold_q        <= '0;
`ifdef AUTO_REPEAT_EN
         rep_q         <= '0;
`endif
      end else begin
         sync1_q       <= sync1_d;
         sync2_q       <= sync2_d;
         stable_q      <= stable_d;
         stable_prev_q <= stable_prev_d;
         for (int i = 0; i < 4; i++) db_cnt_q[i] <= db_cnt_d[i];
         state_q       <= state_d;
         dir_q         <= dir_d;
         latched_q     <= latched_d;
         hold_q        <= hold_d;
`ifdef AUTO_REPEAT_EN
         rep_q         <= rep_d;
`endif
      end
   end

   assign direction  = dir_q;
   assign btn_stable = stable_q;
   assign busy       = (state_q != WAIT_PRESS);

endmodule
`default_nettype wire

// File: tb/tb_direction_input_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------------+
// | tb_direction_input_ctrl : directed + random bench with a behavioural model    |
// | Revision: 1.0                                                                  |
// +------------------------------------------------------------------------------+
module tb_direction_input_ctrl;
   localparam int D = 4;
   localparam int H = 2;
   localparam int R = 10;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] btn_n = 4'hF;
   logic       enable = 1'b0;
   logic [3:0] direction, btn_stable;
   logic       busy;

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   // Reference model: pipeline of raw samples, run lengths of disagreement,
   // and a command described by "cycles left to show" plus a release lock.
   logic [3:0] m_sync1 = 4'hF, m_sync2 = 4'hF, m_stable = 4'h0, m_prev = 4'h0, m_cmd = 4'h0;
   int         m_run [4] = '{0, 0, 0, 0};
   int         m_left = 0;
   bit         m_locked = 1'b0;
   int         m_held = 0;

   always #5 clk = ~clk;

   direction_input_ctrl #(
      .DEBOUNCE_CYCLES(D),
      .HOLD_CYCLES    (H),
      .REPEAT_CYCLES  (R)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .btn_n     (btn_n),
      .enable    (enable),
      .direction (direction),
      .btn_stable(btn_stable),
      .busy      (busy)
   );

   function automatic logic [3:0] exp_dir();
      return (m_left > 0) ? m_cmd : 4'b0000;
   endfunction

   function automatic logic exp_busy();
      return (m_left > 0) || m_locked;
   endfunction

   task automatic model_edge();
      logic [3:0] pr, sv, nst;
      pr = m_stable & ~m_prev;
      if (rst) begin
         m_sync1 = 4'hF; m_sync2 = 4'hF; m_stable = 4'h0; m_prev = 4'h0; m_cmd = 4'h0;
         for (int i = 0; i < 4; i++) m_run[i] = 0;
         m_left = 0; m_locked = 1'b0; m_held = 0;
      end else begin
         if (m_left > 0) begin
            if (!enable || m_left == 1) begin
               m_left = 0; m_locked = 1'b1;
            end else begin
               m_left = m_left - 1;
            end
         end else if (m_locked) begin
            if (m_stable == 4'h0) begin
               m_locked = 1'b0; m_held = 0;
            end
`ifdef AUTO_REPEAT_EN
            else if (m_stable == m_cmd && enable) begin
               m_held = m_held + 1;
               if (m_held == R) begin
                  m_held = 0; m_left = H; m_locked = 1'b0;
               end
            end else begin
               m_held = 0;
            end
`endif
         end else if (enable && pr != 4'h0) begin
            for (int i = 3; i >= 0; i--) if (pr[i]) m_cmd = 4'(1 << i);
            m_left = H;
         end
         sv  = ~m_sync2;
         nst = m_stable;
         for (int i = 0; i < 4; i++) begin
            if (sv[i] != m_stable[i]) m_run[i] = m_run[i] + 1;
            else m_run[i] = 0;
            if (m_run[i] > D) begin
               nst[i] = sv[i]; m_run[i] = 0;
            end
         end
         m_prev   = m_stable;
         m_stable = nst;
         m_sync2  = m_sync1;
         m_sync1  = btn_n;
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; btn_n = 4'hF; enable = 1'b0;
      repeat (2) step();
      n_checks++;
      if ({direction, btn_stable, busy} !== 9'b0) begin
         n_fail++;
         $display("FAIL reset dir=%b stable=%b busy=%b required 0000 0000 0", direction, btn_stable, busy);
      end else n_pass++;
      rst = 1'b0;
      for (int c = 0; c < 4; c++) begin
         step();
         n_checks++;
         if (direction !== exp_dir() || btn_stable !== m_stable || busy !== exp_busy()) begin
            n_fail++;
            $display("FAIL reset_idle c=%0d dir=%b/%b stable=%b/%b busy=%b/%b (got/required)",
                     c, direction, exp_dir(), btn_stable, m_stable, busy, exp_busy());
         end else n_pass++;
      end
   endtask

   task automatic test_single_press();
      enable = 1'b1; btn_n = 4'b1110;
      for (int c = 0; c < 16; c++) begin
         step();
         n_checks++;
         if (btn_stable[0] !== (c >= 6) || busy !== (c >= 7) ||
             direction !== ((c == 7 || c == 8) ? 4'b0001 : 4'b0000)) begin
            n_fail++;
            $display("FAIL single_timing c=%0d dir=%b stable=%b busy=%b", c, direction, btn_stable, busy);
         end else n_pass++;
      end
      btn_n = 4'hF;
      for (int c = 0; c < 12; c++) begin
         step();
         n_checks++;
         if (direction !== exp_dir() || btn_stable !== m_stable || busy !== exp_busy()) begin
            n_fail++;
            $display("FAIL single_release c=%0d dir=%b/%b stable=%b/%b busy=%b/%b (got/required)",
                     c, direction, exp_dir(), btn_stable, m_stable, busy, exp_busy());
         end else n_pass++;
      end
      n_checks++;
      if (busy !== 1'b0 || btn_stable !== 4'h0) begin
         n_fail++;
         $display("FAIL single_idle busy=%b stable=%b required 0 0000", busy, btn_stable);
      end else n_pass++;
   endtask

   task automatic test_bounce();
      enable = 1'b1;
      for (int c = 0; c < 14; c++) begin
         btn_n = (c == 3) ? 4'b1111 : 4'b1011;
         step();
         n_checks++;
         if (direction !== ((c == 11 || c == 12) ? 4'b0100 : 4'b0000)) begin
            n_fail++;
            $display("FAIL bounce c=%0d dir=%b required %b", c, direction,
                     (c == 11 || c == 12) ? 4'b0100 : 4'b0000);
         end else n_pass++;
      end
      btn_n = 4'hF;
      for (int c = 0; c < 14; c++) begin
         step();
         n_checks++;
         if (direction !== exp_dir() || btn_stable !== m_stable || busy !== exp_busy()) begin
            n_fail++;
            $display("FAIL bounce_release c=%0d dir=%b/%b stable=%b/%b busy=%b/%b (got/required)",
                     c, direction, exp_dir(), btn_stable, m_stable, busy, exp_busy());
         end else n_pass++;
      end
   endtask

   task automatic test_simultaneous();
      enable = 1'b1; btn_n = 4'b1001;
      for (int c = 0; c < 14; c++) begin
         step();
         n_checks++;
         if (direction !== ((c == 7 || c == 8) ? 4'b0010 : 4'b0000)) begin
            n_fail++;
            $display("FAIL simultaneous c=%0d dir=%b required %b", c, direction,
                     (c == 7 || c == 8) ? 4'b0010 : 4'b0000);
         end else n_pass++;
      end
      btn_n = 4'b1011;
      for (int c = 0; c < 12; c++) begin
         step();
         n_checks++;
         if (direction !== 4'b0000 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL left_locked c=%0d dir=%b busy=%b required 0000 1", c, direction, busy);
         end else n_pass++;
      end
      btn_n = 4'hF;
      repeat (12) step();
      n_checks++;
      if (busy !== 1'b0 || direction !== 4'b0000) begin
         n_fail++;
         $display("FAIL simultaneous_idle busy=%b dir=%b required 0 0000", busy, direction);
      end else n_pass++;
   endtask

   task automatic test_enable_gate();
      enable = 1'b0; btn_n = 4'b0111;
      for (int c = 0; c < 18; c++) begin
         if (c == 12) enable = 1'b1;
         step();
         n_checks++;
         if (direction !== 4'b0000 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL enable_gate c=%0d dir=%b busy=%b required 0000 0", c, direction, busy);
         end else n_pass++;
      end
      btn_n = 4'hF;
      repeat (10) step();
      btn_n = 4'b0111;
      for (int c = 0; c < 10; c++) begin
         step();
         n_checks++;
         if (direction !== ((c == 7 || c == 8) ? 4'b1000 : 4'b0000)) begin
            n_fail++;
            $display("FAIL enable_repress c=%0d dir=%b required %b", c, direction,
                     (c == 7 || c == 8) ? 4'b1000 : 4'b0000);
         end else n_pass++;
      end
      btn_n = 4'hF;
      repeat (12) step();
   endtask

   task automatic test_reset_mid_issue();
      enable = 1'b1; btn_n = 4'b1110;
      for (int c = 0; c < 8; c++) step();
      n_checks++;
      if (direction !== 4'b0001) begin
         n_fail++;
         $display("FAIL pre_reset_issue dir=%b required 0001", direction);
      end else n_pass++;
      rst = 1'b1;
      step();
      n_checks++;
      if (direction !== 4'b0000 || busy !== 1'b0 || btn_stable !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_mid_issue dir=%b busy=%b stable=%b required 0000 0 0000", direction, busy, btn_stable);
      end else n_pass++;
      rst = 1'b0;
      for (int c = 9; c < 19; c++) begin
         step();
         n_checks++;
         if (direction !== ((c == 16 || c == 17) ? 4'b0001 : 4'b0000)) begin
            n_fail++;
            $display("FAIL held_through_reset c=%0d dir=%b required %b", c, direction,
                     (c == 16 || c == 17) ? 4'b0001 : 4'b0000);
         end else n_pass++;
      end
      btn_n = 4'hF;
      repeat (14) step();
   endtask

   task automatic test_auto_repeat();
      int         pulses;
      int         req;
      logic [3:0] last;
      pulses = 0; last = 4'b0000;
`ifdef AUTO_REPEAT_EN
      req = 3;
`else
      req = 1;
`endif
      enable = 1'b1; btn_n = 4'b1110;
      for (int c = 0; c < 40; c++) begin
         step();
         if (direction == 4'b0001 && last != 4'b0001) pulses++;
         last = direction;
         n_checks++;
         if (direction !== exp_dir() || btn_stable !== m_stable || busy !== exp_busy()) begin
            n_fail++;
            $display("FAIL repeat_model c=%0d dir=%b/%b stable=%b/%b busy=%b/%b (got/required)",
                     c, direction, exp_dir(), btn_stable, m_stable, busy, exp_busy());
         end else n_pass++;
      end
      n_checks++;
      if (pulses !== req) begin
         n_fail++;
         $display("FAIL repeat_pulses got=%0d required=%0d", pulses, req);
      end else n_pass++;
      btn_n = 4'hF;
      repeat (16) step();
   endtask

   task automatic test_random();
      for (int c = 0; c < 800; c++) begin
         for (int b = 0; b < 4; b++) if ($urandom_range(0, 11) == 0) btn_n[b] = ~btn_n[b];
         enable = ($urandom_range(0, 9) != 0);
         rst    = ($urandom_range(0, 149) == 0);
         step();
         n_checks++;
         if (direction !== exp_dir() || btn_stable !== m_stable || busy !== exp_busy()) begin
            n_fail++;
            $display("FAIL random c=%0d dir=%b/%b stable=%b/%b busy=%b/%b (got/required)",
                     c, direction, exp_dir(), btn_stable, m_stable, busy, exp_busy());
         end else n_pass++;
      end
      rst = 1'b0; btn_n = 4'hF; enable = 1'b1;
      repeat (20) step();
      n_checks++;
      if (busy !== 1'b0 || btn_stable !== 4'h0 || direction !== 4'h0) begin
         n_fail++;
         $display("FAIL random_drain busy=%b stable=%b dir=%b required 0 0000 0000", busy, btn_stable, direction);
      end else n_pass++;
   endtask

   initial begin
      test_reset();
      test_single_press();
      test_bounce();
      test_simultaneous();
      test_enable_gate();
      test_reset_mid_issue();
      test_auto_repeat();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
